img_downsample_writer: RTL
==========================

// Module: img_downsample_writer
// PURPOSE
//  Writer side of image_mem. Runs in the camera pixel domain and consumes the RAW2GRAY stream.
//  Crops a centred 448x448 window from each 640x480 frame and box-averages 16x16 blocks.
//  Writes the resulting 28x28 8-bit image to image_mem at addresses 0..783, in raster order.
//  The CPU reads the image back over addr[9:0]. The CPU requests a capture; one full frame is captured per request.
// PARAMETERS
//  OUT_DIM  28   output image side, in blocks
//  BLK      16   block side in pixels; must be a power of 2
//  X0       96   first cropped column (iX_Cont)
//  Y0       16   first cropped row (iY_Cont)
//  PIX_W    12   width of input grey sample
// PORTS
//  D5M_PIXLCLK  in   1   pixel clock; all logic on posedge
//  rst_n        in   1   reset, asynchronous, active-low
//  iGray        in   12  grey sample (sCCD_G)
//  iDVAL        in   1   iGray valid
//  iX_Cont      in   16  column of the current iGray
//  iY_Cont      in   16  row of the current iGray
//  iFVAL        in   1   frame valid, aligned to iGray
//  capture_req  in   1   level from CPU domain; 2-flop synchronised internally
//  busy         out  1   high in ARM, WAIT_FRAME or CAPTURE
//  done         out  1   a complete image is in image_mem
//  we           out  1   image_mem write enable, single-cycle pulse
//  waddr        out  10  image_mem write address
//  wdata        out  8   image_mem write data
// BEHAVIOUR
//  Reset values: busy=0, done=0, we=0, waddr=0, wdata=0, state=IDLE.
//    All accumulators and counters are also cleared on reset.
//  FSM states: IDLE, ARM, WAIT_FRAME, CAPTURE, DONE.
//  - IDLE: synced req=1 -> ARM.
//  - ARM: wait for iFVAL=0 -> WAIT_FRAME. A request raised mid-frame therefore never captures a partial frame.
//  - WAIT_FRAME: iFVAL=1 -> CAPTURE. Clear the write counter and all accumulators.
//  - CAPTURE: accumulate as below.
//      After the write to address 783 -> DONE.
//      If iFVAL falls before 784 writes -> ARM, discarding the partial image; done stays 0.
//  - DONE: done=1, held until synced req=0 -> IDLE, where done=0.
//      This is a 4-phase handshake; a req still high in DONE never retriggers a capture.
//  Crop: a sample is in-window when iDVAL=1, X0<=x<X0+OUT_DIM*BLK and Y0<=y<Y0+OUT_DIM*BLK.
//    Out-of-window samples are ignored.
//  Block indices: bc=(x-X0)/BLK, br=(y-Y0)/BLK. Both are shifts, since BLK is a power of 2.
//  Accumulators: OUT_DIM entries of PIX_W+2*log2(BLK) = 20 bits each.
//    Each in-window sample does acc[bc] += iGray.
//  Final sample of a block (row (y-Y0)%BLK==BLK-1 and column (x-X0)%BLK==BLK-1):
//    - sum = acc[bc] + iGray;
//    - next cycle: we=1, wdata=sum[19:12] (the mean, truncated to its upper 8 bits), waddr=write counter;
//    - acc[bc] is cleared in the same cycle as the write is launched;
//    - write counter increments.
//  Latency: 1 cycle from the final sample to the we pulse. There is at most 1 write per 16 samples, so no backpressure is needed.
//  Write counter saturates at 783: no write beyond 783 and no wrap-around.
//  Frame end and final block sample in the same cycle: the write still issues, then the FSM goes to DONE.
//  Reset mid-CAPTURE: outputs drop to their reset values immediately. image_mem contents are undefined until the next done.
// CONFIGURATION
//  IMG_INVERT_EN defined: wdata = 8'hFF - sum[19:12].
//    Dark ink on white paper then becomes a white digit on black, matching the MNIST-trained weights.
//  IMG_INVERT_EN undefined: wdata = sum[19:12] unmodified.
// STRUCTURE
//  Package img_pkg holds:
//    - localparams OUT_DIM, BLK, IMG_PIX=784, IMG_ADDR_W=10, ACC_W=20;
//    - typedef enum logic[2:0] cap_state_t {IDLE,ARM,WAIT_FRAME,CAPTURE,DONE}.
//  Sub-module box_acc_bank: OUT_DIM x ACC_W accumulator register file.
//    Ports: index, add value, add enable, clear.
//    Output: combinational sum (acc+value) for the final-sample write.
//  The req synchroniser is inline and uses 2 flops.
// TESTING
//  T1 constant frame: iGray=12'hFFF, full 640x480 frame after req.
//     -> exactly 784 we pulses, waddr 0..783 ascending, wdata all 8'hFF; done=1; busy=0.
//     With IMG_INVERT_EN: wdata all 8'h00.
//  T2 single block: iGray=12'h800 for x 96..111, y 16..31, else 0.
//     -> addr 0 = 8'h80; addrs 1..783 = 8'h00.
//     Same pattern at x 528..543, y 448..463 -> addr 783 = 8'h80.
//  T3 crop edges: iGray=12'hFFF only at x=95, x=544, y=15 and y=464.
//     -> all 784 writes carry 8'h00.
//  T4 aborted frame: iFVAL dropped after 400 writes.
//     -> done stays 0 and the FSM returns to ARM.
//     Next full frame: 784 writes restarting at waddr=0, then done=1.
//  T5 handshake: req raised mid-frame -> no we until the next iFVAL rise.
//     Req held after done -> done stays 1 and no second capture.
//     Req dropped -> done=0 within 3 clocks.
//  T6 reset: rst_n pulsed low mid-CAPTURE.
//     -> same cycle, asynchronously: we=0, busy=0, done=0, waddr=0.
//     After release: IDLE until a new req.

Source files
------------

// File: rtl/img_pkg.sv
// Shared sizing constants and capture FSM encoding for the image downsample writer.
`default_nettype none

package img_pkg;

   localparam int OUT_DIM    = 28;
   localparam int BLK        = 16;
   localparam int IMG_PIX    = OUT_DIM * OUT_DIM;
   localparam int IMG_ADDR_W = 10;
   localparam int ACC_W      = 20;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ARM        = 3'd1,
      WAIT_FRAME = 3'd2,
      CAPTURE    = 3'd3,
      DONE       = 3'd4
   } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/img_downsample_writer_box_acc_bank.sv
// box_acc_bank: one accumulator per output column of blocks, with a combinational acc+value tap.
`default_nettype none

module box_acc_bank
   import img_pkg::*;
#(
   parameter int DEPTH = OUT_DIM,
   parameter int WIDTH = ACC_W,
   parameter int VAL_W = 12,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             D5M_PIXLCLK,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [VAL_W-1:0] i_val,
   input  logic             i_add,
   input  logic             i_clr,
   input  logic             i_clr_all,
   output logic [WIDTH-1:0] o_sum
);

   logic [WIDTH-1:0] r_acc [DEPTH];
   logic [WIDTH-1:0] w_sel;
   logic [WIDTH-1:0] w_sum;

   // Explicit mux so an index beyond DEPTH-1 reads as zero instead of indexing off the array.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_idx == IDX_W'(i)) w_sel = r_acc[i];
      end
   end

   assign w_sum = w_sel + WIDTH'(i_val);
   assign o_sum = w_sum;

   always_ff @(posedge D5M_PIXLCLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_acc[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_clr_all) begin
               r_acc[i] <= '0;
            end else if (i_idx == IDX_W'(i)) begin
               if (i_clr)      r_acc[i] <= '0;
               else if (i_add) r_acc[i] <= w_sum;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/img_downsample_writer.sv
// img_downsample_writer: crops a centred window, box-averages BLKxBLK blocks, writes OUT_DIM^2 bytes.
// Define IMG_INVERT_EN to store 8'hFF minus the block mean instead of the mean.
`default_nettype none

module img_downsample_writer
   import img_pkg::*;
#(
   parameter int OUT_DIM = img_pkg::OUT_DIM,
   parameter int BLK     = img_pkg::BLK,
   parameter int X0      = 96,
   parameter int Y0      = 16,
   parameter int PIX_W   = 12
) (
   input  logic                  D5M_PIXLCLK,
   input  logic                  rst_n,
   input  logic [PIX_W-1:0]      iGray,
   input  logic                  iDVAL,
   input  logic [15:0]           iX_Cont,
   input  logic [15:0]           iY_Cont,
   input  logic                  iFVAL,
   input  logic                  capture_req,
   output logic                  busy,
   output logic                  done,
   output logic                  we,
   output logic [IMG_ADDR_W-1:0] waddr,
   output logic [7:0]            wdata
);

   localparam int c_LOG2_BLK = $clog2(BLK);
   localparam int c_ACC_W    = PIX_W + 2 * c_LOG2_BLK;
   localparam int c_IDX_W    = $clog2(OUT_DIM);
   localparam int c_SPAN     = OUT_DIM * BLK;
   localparam logic [IMG_ADDR_W-1:0] c_LAST = IMG_ADDR_W'(OUT_DIM * OUT_DIM - 1);

   cap_state_t r_state, w_next;

   logic                  r_req_s1, r_req_s2;
   logic                  r_we;
   logic [IMG_ADDR_W-1:0] r_waddr, r_wcnt;
   logic [7:0]            r_wdata;

   logic                  w_in_win, w_last, w_capt, w_fire;
   logic [c_LOG2_BLK-1:0] w_dx_lo, w_dy_lo;
   logic [c_IDX_W-1:0]    w_idx;
   logic [c_ACC_W-1:0]    w_sum;
   logic [7:0]            w_pix;
   logic                  w_unused;

   assign w_in_win = iDVAL
                   && (iX_Cont >= 16'(X0)) && (iX_Cont < 16'(X0 + c_SPAN))
                   && (iY_Cont >= 16'(Y0)) && (iY_Cont < 16'(Y0 + c_SPAN));
   assign w_dx_lo  = c_LOG2_BLK'(iX_Cont - 16'(X0));
   assign w_dy_lo  = c_LOG2_BLK'(iY_Cont - 16'(Y0));
   assign w_idx    = c_IDX_W'((iX_Cont - 16'(X0)) >> c_LOG2_BLK);
   assign w_last   = (&w_dx_lo) && (&w_dy_lo);
   assign w_capt   = (r_state == CAPTURE);
   assign w_fire   = w_capt && w_in_win && w_last;

   box_acc_bank #(
      .DEPTH (OUT_DIM),
      .WIDTH (c_ACC_W),
      .VAL_W (PIX_W),
      .IDX_W (c_IDX_W)
   ) u_bank (
      .D5M_PIXLCLK (D5M_PIXLCLK),
      .rst_n       (rst_n),
      .i_idx       (w_idx),
      .i_val       (iGray),
      .i_add       (w_capt && w_in_win),
      .i_clr       (w_fire),
      .i_clr_all   (r_state == WAIT_FRAME),
      .o_sum       (w_sum)
   );

`ifdef IMG_INVERT_EN
   assign w_pix = 8'hFF - w_sum[c_ACC_W-1 -: 8];
`else
   assign w_pix = w_sum[c_ACC_W-1 -: 8];
`endif

   assign w_unused = &{1'b0, w_sum[c_ACC_W-9:0]};

   always_ff @(posedge D5M_PIXLCLK or negedge rst_n) begin
      if (!rst_n) begin
         r_req_s1 <= 1'b0;
         r_req_s2 <= 1'b0;
         r_state  <= IDLE;
      end else begin
         r_req_s1 <= capture_req;
         r_req_s2 <= r_req_s1;
         r_state  <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:       if (r_req_s2) w_next = ARM;
         ARM:        if (!iFVAL) w_next = WAIT_FRAME;
         WAIT_FRAME: if (iFVAL) w_next = CAPTURE;
         // The closing write wins over a simultaneous frame end.
         CAPTURE: begin
            if (w_fire && (r_wcnt == c_LAST)) w_next = DONE;
            else if (!iFVAL)                  w_next = ARM;
         end
         DONE:       if (!r_req_s2) w_next = IDLE;
         default:    w_next = IDLE;
      endcase
   end

   always_ff @(posedge D5M_PIXLCLK or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_wcnt  <= '0;
      end else begin
         r_we <= w_fire;
         if (r_state == WAIT_FRAME) r_wcnt <= '0;
         if (w_fire) begin
            r_waddr <= r_wcnt;
            r_wdata <= w_pix;
            if (r_wcnt != c_LAST) r_wcnt <= r_wcnt + 1'b1;
         end
      end
   end

   assign busy  = (r_state == ARM) || (r_state == WAIT_FRAME) || (r_state == CAPTURE);
   assign done  = (r_state == DONE);
   assign we    = r_we;
   assign waddr = r_waddr;
   assign wdata = r_wdata;

endmodule

`default_nettype wire
